timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped timer/counter device that sits directly downstream of the CPU's bridge port. It consumes the bus signals (address, write enable, write data), returns read data, and produces one hardware interrupt line that feeds an `HWInt` bit. It provides a 32-bit down-counter with one-shot and auto-reload modes. Software programs it with ordinary `sw`/`lw` instructions.

## Interface
- No parameters. The base address is decoded by the bridge and delivered as `sel`.
- `clk  in  1` — system clock; all state changes on the rising edge.
- `reset  in  1` — asynchronous, active-low; one clock domain.
- `sel  in  1` — device selected by the bridge for the current access.
- `addr  in  2` — word offset (`PrAddr[3:2]`): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we  in  1` — write strobe; a write happens only when `sel & we`.
- `wdata  in  32` — write data.
- `rdata  out  32` — combinational read data for `addr`; 0 when `!sel` or when `addr` is 3.
- `irq  out  1` — interrupt request, equal to `CTRL.IM & irq_flag`.

## Operation
- **CTRL bit fields:**
  - [0] Enable.
  - [2:1] Mode: 0 = one-shot, 1 = auto-reload, 2/3 = treated as 0.
  - [3] IM (interrupt mask).
  - [31:4] read as 0; writes to them are ignored.
- **PRESET:** 32-bit read/write register.
- **COUNT:** 32-bit counter, read-only by default (see Configuration).
- **FSM states and transitions:**
  - IDLE: COUNT holds. If Enable = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if Enable = 0, go to IDLE. Else if COUNT == 0, go to INT and set `irq_flag`. Else COUNT <= COUNT − 1.
  - INT (mode 0): Enable <= 0; go to IDLE; `irq_flag` stays set.
  - INT (mode 1): `irq_flag` clears on exit; go to LOAD.
- **Software write to CTRL or PRESET, from any state:**
  - the register is updated;
  - the FSM is forced to IDLE;
  - `irq_flag` is cleared. This is the mode-0 acknowledge.
- **Simultaneous events:** a software write to CTRL in the same cycle as INT clearing Enable → the software value wins.
- **PRESET = 0:** LOAD → CNT sees 0 → INT. No underflow wrap.
- **COUNT arithmetic:** unsigned 32-bit. COUNT never decrements below 0.
- **Reset values (reset low):** CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, `irq_flag` = 0, `irq` = 0.
- **Reset released mid-count:** the block restarts from IDLE with all registers cleared.

## Timing
- Register writes take effect at the clock edge where `sel & we` is high. Reads are same-cycle combinational.
- Enable written at edge k with PRESET = N:
  - LOAD at edge k+1;
  - COUNT = N after edge k+2;
  - COUNT reaches 0 after edge k+2+N;
  - `irq_flag` = 1 after edge k+3+N.
- Mode 1:
  - irq period is N+3 cycles;
  - `irq` is high for exactly 1 cycle per period (the INT state).
- Mode 0: `irq` stays high, given IM = 1, until software writes CTRL or PRESET.
- COUNT is visible on `rdata` in the same cycle that it updates in the register.

## Configuration
- Macro: `TC_COUNT_WRITE_EN`.
- **Defined:**
  - a write to offset 2 loads COUNT directly and keeps the current FSM state;
  - if the state is CNT, counting continues from the written value.
- **Undefined:**
  - writes to offset 2 are ignored;
  - they do not force IDLE and do not clear `irq_flag`.

## Structure
- **Shared package `timer_pkg`:**
  - register offsets (CTRL/PRESET/COUNT);
  - CTRL bit positions;
  - mode encodings;
  - FSM state enum (IDLE, LOAD, CNT, INT).
- The bridge address decode uses the same package.
- Single module; no sub-module. The register file and FSM together are under 250 lines.

## Test plan
- **Reset defaults:** hold reset low mid-count, then release → `rdata` reads 0 at offsets 0/1/2, `irq` = 0, state IDLE.
- **Mode 0, PRESET = 5:** write PRESET = 5, then CTRL = 0x9 → `irq` rises 8 cycles after the CTRL write edge and stays high. COUNT reads 0 and CTRL reads 0x8. Writing CTRL = 0x8 drops `irq` the next cycle.
- **Mode 1, PRESET = 3, IM = 1 (CTRL = 0xB):** → `irq` pulses 1 cycle wide, every 6 cycles, for at least 4 periods.
- **Masking:** mode 0 with CTRL = 0x1 (IM = 0) → `irq` stays 0 while INT occurs and Enable self-clears. Setting IM via a CTRL write also clears `irq_flag`, so `irq` remains 0.
- **Abort and edge cases:**
  - write CTRL = 0 while COUNT = 100 → COUNT freezes at its current value; no irq;
  - PRESET = 0 with Enable set → `irq` after 3 cycles.
- **Macro on:** with `TC_COUNT_WRITE_EN`, write COUNT = 2 during CNT → INT follows 3 cycles later. With the macro off, the same write is ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer/counter: register offsets,
// CTRL bit positions, mode encodings and FSM states (also used by the bridge decode).
package timer_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1
  } modeT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } stateT;

  // Encodings 2 and 3 behave as one-shot.
  function automatic logic isReload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with one-shot / auto-reload modes and a masked irq.
// Define TC_COUNT_WRITE_EN to make COUNT (offset 2) software-writable.
module timer_counter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic        ctrlEn;
  logic [1:0]  ctrlMode;
  logic        ctrlIm;
  logic [31:0] presetReg;
  logic [31:0] countReg;
  logic [31:0] countNext;
  logic        irqFlag;
  stateT       state;
  stateT       stateNext;

  logic wrEn;
  logic ctrlWrite;
  logic presetWrite;
  logic countWrite;
  logic swForce;
  logic enClear;
  logic flagSet;
  logic flagClear;

  assign wrEn        = sel & we;
  assign ctrlWrite   = wrEn && (addr == OFF_CTRL);
  assign presetWrite = wrEn && (addr == OFF_PRESET);
`ifdef TC_COUNT_WRITE_EN
  assign countWrite  = wrEn && (addr == OFF_COUNT);
`else
  assign countWrite  = 1'b0;
`endif
  assign swForce     = ctrlWrite | presetWrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every output of this block is given a default first, so no path infers a latch.
  always_comb begin
    stateNext = state;
    countNext = countReg;
    enClear   = 1'b0;
    flagSet   = 1'b0;
    flagClear = 1'b0;
    unique case (state)
      IDLE: if (ctrlEn) stateNext = LOAD;
      LOAD: begin
        countNext = presetReg;
        stateNext = CNT;
      end
      CNT: begin
        if (!ctrlEn) begin
          stateNext = IDLE;
        end else if (countReg == 32'd0) begin
          stateNext = INT;
          flagSet   = 1'b1;
        end else begin
          countNext = countReg - 32'd1;
        end
      end
      INT: begin
        if (isReload(ctrlMode)) begin
          flagClear = 1'b1;
          stateNext = LOAD;
        end else begin
          enClear   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // A CTRL/PRESET write overrides whatever the FSM wanted this edge and acts as the ack.
    if (swForce) begin
      stateNext = IDLE;
      countNext = countReg;
      enClear   = 1'b0;
      flagSet   = 1'b0;
      flagClear = 1'b1;
    end
    if (countWrite) countNext = wdata;
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlEn    <= 1'b0;
      ctrlMode  <= 2'd0;
      ctrlIm    <= 1'b0;
      presetReg <= '0;
      countReg  <= '0;
      irqFlag   <= 1'b0;
    end else begin
      countReg <= countNext;
      if (ctrlWrite) begin
        ctrlEn   <= wdata[CTRL_EN_BIT];
        ctrlMode <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        ctrlIm   <= wdata[CTRL_IM_BIT];
      end else if (enClear) begin
        ctrlEn <= 1'b0;
      end
      if (presetWrite) presetReg <= wdata;
      if (flagClear)    irqFlag <= 1'b0;
      else if (flagSet) irqFlag <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        OFF_CTRL:   rdata = {28'd0, ctrlIm, ctrlMode, ctrlEn};
        OFF_PRESET: rdata = presetReg;
        OFF_COUNT:  rdata = countReg;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = ctrlIm & irqFlag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: the driver queues expected read data and
// cycle-stamped irq values; a negedge monitor pops and compares them.
module tb_timer_counter;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        rdStrobe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] rdExpQ[$];
  string       rdNameQ[$];
  int          irqCycQ[$];
  logic        irqValQ[$];
  string       irqNameQ[$];

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  always @(negedge clk) begin
    if (rdStrobe && rdExpQ.size() > 0)
      check(rdNameQ.pop_front(), rdata, rdExpQ.pop_front());
    while (irqCycQ.size() > 0 && irqCycQ[0] == cyc) begin
      void'(irqCycQ.pop_front());
      check(irqNameQ.pop_front(), {31'd0, irq}, {31'd0, irqValQ.pop_front()});
    end
  end

  task automatic expIrq(input int c, input logic v, input string n);
    irqCycQ.push_back(c);
    irqValQ.push_back(v);
    irqNameQ.push_back(n);
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d, output int e);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    e = cyc;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] a, input logic [31:0] exp, input string n);
    sel = 1'b1; we = 1'b0; addr = a;
    rdExpQ.push_back(exp);
    rdNameQ.push_back(n);
    rdStrobe = 1'b1;
    @(posedge clk);
    #1;
    rdStrobe = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, k, j;
    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0; rdStrobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset in the middle of a count clears everything.
    busWrite(OFF_PRESET, 32'd100, e);
    busWrite(OFF_CTRL, 32'h1, e);
    idle(20);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    expIrq(cyc, 1'b0, "rst irq");
    busRead(OFF_CTRL,   32'd0, "rst ctrl");
    busRead(OFF_PRESET, 32'd0, "rst preset");
    busRead(OFF_COUNT,  32'd0, "rst count");
    idle(3);
    busRead(OFF_COUNT, 32'd0, "rst idle count");

    // Mode 0, PRESET = 5: irq 8 cycles after the CTRL write, held until ack.
    busWrite(OFF_PRESET, 32'd5, e);
    busWrite(OFF_CTRL, 32'h9, k);
    for (int i = 1; i <= 12; i++) expIrq(k + i, i >= 8, "m0 irq");
    idle(12);
    busRead(OFF_COUNT, 32'd0, "m0 count");
    busRead(OFF_CTRL,  32'h8, "m0 ctrl");
    expIrq(cyc, 1'b1, "m0 irq held");
    busWrite(OFF_CTRL, 32'h8, e);
    expIrq(e,     1'b0, "m0 ack");
    expIrq(e + 1, 1'b0, "m0 ack hold");
    idle(2);

    // Mode 1, PRESET = 3: 1-cycle pulse every 6 cycles.
    busWrite(OFF_PRESET, 32'd3, e);
    busWrite(OFF_CTRL, 32'hB, k);
    for (int i = 1; i <= 25; i++)
      expIrq(k + i, (i == 6 || i == 12 || i == 18 || i == 24), "m1 irq");
    idle(25);
    busWrite(OFF_CTRL, 32'h0, e);
    idle(2);

    // Masked one-shot: flag sets but irq stays low; setting IM acks the flag.
    busWrite(OFF_PRESET, 32'd2, e);
    busWrite(OFF_CTRL, 32'h1, k);
    for (int i = 1; i <= 8; i++) expIrq(k + i, 1'b0, "mask irq");
    idle(8);
    busRead(OFF_CTRL,  32'h0, "mask en cleared");
    busRead(OFF_COUNT, 32'd0, "mask count");
    busWrite(OFF_CTRL, 32'h8, e);
    for (int i = 0; i < 3; i++) expIrq(e + i, 1'b0, "mask im set");
    idle(3);
    busWrite(OFF_CTRL, 32'h0, e);

    // Abort at COUNT = 100: value freezes, no irq.
    busWrite(OFF_PRESET, 32'd200, e);
    busWrite(OFF_CTRL, 32'h1, k);
    idle(101);
    busRead(OFF_COUNT, 32'd101, "abort pre");
    busWrite(OFF_CTRL, 32'h0, e);
    busRead(OFF_COUNT, 32'd100, "abort freeze");
    idle(3);
    expIrq(cyc, 1'b0, "abort irq");
    busRead(OFF_COUNT, 32'd100, "abort freeze later");

    // PRESET = 0: irq 3 cycles after enable, no wrap.
    busWrite(OFF_PRESET, 32'd0, e);
    busWrite(OFF_CTRL, 32'h9, k);
    expIrq(k + 1, 1'b0, "p0 irq");
    expIrq(k + 2, 1'b0, "p0 irq");
    expIrq(k + 3, 1'b1, "p0 irq rise");
    expIrq(k + 4, 1'b1, "p0 irq held");
    idle(4);
    busRead(OFF_COUNT, 32'd0, "p0 count");
    busWrite(OFF_CTRL, 32'h0, e);
    expIrq(e, 1'b0, "p0 ack");

    // Writing COUNT = 2 during CNT.
    busWrite(OFF_PRESET, 32'd50, e);
    busWrite(OFF_CTRL, 32'h9, k);
    idle(4);
    busWrite(OFF_COUNT, 32'd2, j);
`ifdef TC_COUNT_WRITE_EN
    expIrq(j + 2, 1'b0, "cw irq");
    expIrq(j + 3, 1'b1, "cw irq rise");
    busRead(OFF_COUNT, 32'd2, "cw count");
`else
    expIrq(j + 3, 1'b0, "cw ignored irq");
    busRead(OFF_COUNT, 32'd47, "cw ignored count");
`endif
    idle(4);
    busWrite(OFF_CTRL, 32'h0, e);
    idle(3);

    checks++;
    if (irqCycQ.size() != 0 || rdExpQ.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d irq and %0d read expectations never compared",
               irqCycQ.size(), rdExpQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
